// File: rtl/dm_hart_ctrl.sv
// Multi-hart run-control engine for the debug module: per-hart halt/resume FSMs,
// hart-array-mask selection, halt groups, havereset tracking and dmstatus any/all summaries.
module dm_hart_ctrl #(
    parameter int NrHarts    = 4,
    parameter int NrGroups   = 2,
    parameter int HartSelLen = 20
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       dmactive_i,
    input  logic [HartSelLen-1:0]      hartsel_i,
    input  logic                       hasel_i,
    input  logic [NrHarts-1:0]         hamask_i,
    input  logic                       haltreq_i,
    input  logic                       resumereq_i,
    input  logic                       ackhavereset_i,
    input  logic                       grp_wr_valid_i,
    input  logic [$clog2(NrHarts):0]   grp_wr_hart_i,
    input  logic [3:0]                 grp_wr_id_i,
    input  logic [NrHarts-1:0]         halted_i,
    input  logic [NrHarts-1:0]         resuming_i,
    input  logic [NrHarts-1:0]         hart_reset_i,
    input  logic [NrHarts-1:0]         unavailable_i,
    output logic [NrHarts-1:0]         debug_req_o,
    output logic [NrHarts-1:0]         resume_o,
    output logic                       anyhalted_o,
    output logic                       allhalted_o,
    output logic                       anyrunning_o,
    output logic                       allrunning_o,
    output logic                       anyunavail_o,
    output logic                       allunavail_o,
    output logic                       anynonexistent_o,
    output logic                       allnonexistent_o,
    output logic                       anyresumeack_o,
    output logic                       allresumeack_o,
    output logic                       anyhavereset_o,
    output logic                       allhavereset_o
);

    localparam int HartIdxW = $clog2(NrHarts) + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTING,
        ST_HALTED,
        ST_RESUMING
    } hart_state_e;

    hart_state_e        r_state [NrHarts];
    logic [3:0]         r_group [NrHarts];
    logic [NrHarts-1:0] r_debugReq;
    logic [NrHarts-1:0] r_resume;
    logic [NrHarts-1:0] r_resumeAck;
    logic [NrHarts-1:0] r_haveReset;
    logic [NrHarts-1:0] r_haltedPrev;

    logic [NrHarts-1:0] w_match;
    logic [NrHarts-1:0] w_sel;
    logic               w_selNz;
    logic               w_nonexist;
    logic [NrHarts-1:0] w_haltedRise;
    logic [15:0]        w_trigGroups;
    logic [NrHarts-1:0] w_grpHit;
    logic [NrHarts-1:0] w_isHalted;
    logic [NrHarts-1:0] w_isRunning;

    // An out-of-range hartsel matches no hart, which is exactly the nonexistent case.
    always_comb begin
        for (int i = 0; i < NrHarts; i++) begin
            w_match[i] = (hartsel_i == HartSelLen'(i));
        end
        w_nonexist = ~|w_match;
        w_sel      = w_match | (hasel_i ? hamask_i : '0);
        w_selNz    = |w_sel;
    end

    assign w_haltedRise = halted_i & ~r_haltedPrev;

    always_comb begin
        w_trigGroups = '0;
        for (int j = 0; j < NrHarts; j++) begin
            if (w_haltedRise[j] && (r_group[j] != 4'd0)) begin
                w_trigGroups[r_group[j]] = 1'b1;
            end
        end
        for (int k = 0; k < NrHarts; k++) begin
            w_grpHit[k] = (r_group[k] != 4'd0) && w_trigGroups[r_group[k]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !dmactive_i) begin
            for (int i = 0; i < NrHarts; i++) begin
                r_state[i] <= ST_RUN;
            end
            r_debugReq  <= '0;
            r_resume    <= '0;
            r_resumeAck <= '0;
        end else begin
            for (int i = 0; i < NrHarts; i++) begin
                if (hart_reset_i[i]) begin
                    r_state[i]    <= ST_RUN;
                    r_debugReq[i] <= 1'b0;
                    r_resume[i]   <= 1'b0;
                end else begin
                    case (r_state[i])
                        ST_RUN: begin
                            if (halted_i[i]) begin
                                r_state[i]    <= ST_HALTED;
                                r_debugReq[i] <= 1'b0;
                            end else if ((haltreq_i && w_sel[i]) || w_grpHit[i]) begin
                                r_state[i]    <= ST_HALTING;
                                r_debugReq[i] <= 1'b1;
                            end
                        end
                        ST_HALTING: begin
                            if (halted_i[i]) begin
                                r_state[i]    <= ST_HALTED;
                                r_debugReq[i] <= 1'b0;
                            end
                        end
                        ST_HALTED: begin
                            // A pending halt or a same-cycle group trigger outranks a resume.
                            if (!halted_i[i]) begin
                                r_state[i] <= ST_RUN;
                            end else if (resumereq_i && w_sel[i] && !haltreq_i && !w_grpHit[i]) begin
                                r_state[i]     <= ST_RESUMING;
                                r_resume[i]    <= 1'b1;
                                r_resumeAck[i] <= 1'b0;
                            end
                        end
                        ST_RESUMING: begin
                            if (resuming_i[i]) begin
                                r_state[i]     <= ST_RUN;
                                r_resume[i]    <= 1'b0;
                                r_resumeAck[i] <= 1'b1;
                            end
                        end
                        default: begin
                            r_state[i]    <= ST_RUN;
                            r_debugReq[i] <= 1'b0;
                            r_resume[i]   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // havereset survives a dmactive clear; a hart reset beats a simultaneous ack.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_haveReset  <= '1;
            r_haltedPrev <= '0;
            for (int i = 0; i < NrHarts; i++) begin
                r_group[i] <= 4'd0;
            end
        end else begin
            r_haltedPrev <= halted_i;
            for (int i = 0; i < NrHarts; i++) begin
                if (hart_reset_i[i]) begin
                    r_haveReset[i] <= 1'b1;
                end else if (ackhavereset_i && w_sel[i]) begin
                    r_haveReset[i] <= 1'b0;
                end
                if (!dmactive_i) begin
                    r_group[i] <= 4'd0;
                end else if (grp_wr_valid_i && (grp_wr_hart_i == HartIdxW'(i))
                             && (grp_wr_id_i <= 4'(NrGroups))) begin
                    r_group[i] <= grp_wr_id_i;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NrHarts; i++) begin
            w_isHalted[i]  = (r_state[i] == ST_HALTED) && !unavailable_i[i];
            w_isRunning[i] = ((r_state[i] == ST_RUN) || (r_state[i] == ST_HALTING))
                             && !unavailable_i[i];
        end
    end

    assign debug_req_o = r_debugReq;
    assign resume_o    = r_resume;

    assign anyhalted_o      = |(w_isHalted & w_sel);
    assign allhalted_o      = w_selNz & (&(w_isHalted | ~w_sel));
    assign anyrunning_o     = |(w_isRunning & w_sel);
    assign allrunning_o     = w_selNz & (&(w_isRunning | ~w_sel));
    assign anyunavail_o     = |(unavailable_i & w_sel);
    assign allunavail_o     = w_selNz & (&(unavailable_i | ~w_sel));
    assign anyresumeack_o   = |(r_resumeAck & w_sel);
    assign allresumeack_o   = w_selNz & (&(r_resumeAck | ~w_sel));
    assign anyhavereset_o   = |(r_haveReset & w_sel);
    assign allhavereset_o   = w_selNz & (&(r_haveReset | ~w_sel));
    assign anynonexistent_o = w_nonexist;
    assign allnonexistent_o = w_nonexist;

endmodule

// File: doc/dm_hart_ctrl.md
# dm_hart_ctrl

Parametrised multi-hart run-control engine for the debug module. It sits between the debug CSR block and the debug memory/hart interface, and tracks halt, resume and havereset state per hart. It adds hart-array-mask selection, halt groups with cross-hart halt propagation, and the any/all status aggregation that dmstatus needs. The single-hart `haltreq`/`resumereq` plumbing is replaced by this block for NrHarts up to 32.

## Interface
Parameters:
- `NrHarts`, 4: number of harts (1..32).
- `NrGroups`, 2: number of halt groups (1..15); group 0 means "no group".
- `HartSelLen`, 20: width of `hartsel_i`.

Ports:
- `clk_i`  in  1  clock; the block has one clock.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `dmactive_i`  in  1  low = soft clear; see Operation.
- `hartsel_i`  in  HartSelLen  selected hart index.
- `hasel_i`  in  1  enables hart array mask.
- `hamask_i`  in  NrHarts  hart array mask.
- `haltreq_i`  in  1  level halt request from dmcontrol.
- `resumereq_i`  in  1  one-cycle resume request pulse.
- `ackhavereset_i`  in  1  one-cycle pulse.
- `grp_wr_valid_i`  in  1  group assignment strobe.
- `grp_wr_hart_i`  in  $clog2(NrHarts)+1  target hart.
- `grp_wr_id_i`  in  4  group id.
- `halted_i`  in  NrHarts  hart is parked in the debug ROM.
- `resuming_i`  in  NrHarts  one-cycle pulse when a hart leaves the debug ROM.
- `hart_reset_i`  in  NrHarts  one-cycle pulse when a hart leaves reset.
- `unavailable_i`  in  NrHarts  hart is powered down or unavailable.
- `debug_req_o`  out  NrHarts  registered debug request per hart.
- `resume_o`  out  NrHarts  registered resume request per hart.
- `any/all` × `halted`, `running`, `unavail`, `nonexistent`, `resumeack`, `havereset` `_o`  out  1 each  dmstatus summary.

## Operation
**Selection**
- `sel` = one-hot(`hartsel_i`) when `hartsel_i` < NrHarts, else 0.
- When `hasel_i`=1, `sel` |= `hamask_i`.
- Nonexistent means `hartsel_i` ≥ NrHarts. `anynonexistent_o` = `allnonexistent_o` = that condition.

**Per-hart FSM** (states RUN, HALTING, HALTED, RESUMING; reset state RUN)
- RUN → HALTING on (`haltreq_i` & `sel[i]`) or a group trigger.
- RUN or HALTING → HALTED on `halted_i[i]`. This also covers unrequested entry, e.g. ebreak.
- HALTED → RESUMING on `resumereq_i` & `sel[i]` & !`haltreq_i`. On this transition, clear `resumeack[i]`.
- RESUMING → RUN on `resuming_i[i]`; set `resumeack[i]`.
- HALTED → RUN on `halted_i[i]` falling without a resume; `resumeack` is unchanged.
- Any state → RUN on `hart_reset_i[i]`.
- `resumereq_i` to a hart not in HALTED is ignored.
- `debug_req_o[i]` = 1 exactly while the state is HALTING.
- `resume_o[i]` = 1 exactly while the state is RESUMING.

**Halt groups**
- `group[i]` is 4 bits, reset 0.
- A `grp_wr_valid_i` pulse writes `grp_wr_id_i`. The write is ignored if the hart index ≥ NrHarts or the id > NrGroups.
- Group trigger: hart j with `group[j]`≠0 sees `halted_i[j]` rise (HALTED entry). Every other hart k with `group[k]`=`group[j]` that is in RUN goes to HALTING.
- Several triggering harts in one cycle OR their groups.

**Havereset**
- `havereset[i]`: reset value 1; set by `hart_reset_i[i]`; cleared by `ackhavereset_i` & `sel[i]`.

**Unavailable harts**
- A hart with `unavailable_i[i]`=1 counts as unavail and as neither halted nor running.
- Its FSM state and pending HALTING are retained.

**Summary outputs**
- Combinational over `sel`, computed from the registered state.
- any* = OR over selected harts.
- all* = AND over selected harts, forced to 0 when `sel`=0.
- halted = state HALTED.
- running = RUN or HALTING.

**dmactive_i low**
- FSMs return to RUN, `resumeack` and groups are cleared, and outputs drop next cycle.
- `havereset` is preserved.

## Timing
- Every registered output is 0 after reset. Exceptions: `anyhavereset_o`/`allhavereset_o` equal 1 when `sel`≠0.
- `haltreq_i` asserted at cycle N → `debug_req_o` high at N+1.
- `halted_i[i]` high at N → `debug_req_o[i]` low and `anyhalted_o` high at N+1.
- Group members' `debug_req_o` high at N+1, which is one cycle of propagation.
- `resumereq_i` at N → `resume_o` high at N+1, held until `resuming_i`. `resuming_i` at M → `resume_o` low and resumeack at M+1.
- Simultaneous events:
  - `haltreq_i` and `resumereq_i` together: halt wins and resume is dropped.
  - `hart_reset_i` and `ackhavereset_i` for the same hart: havereset is set.
  - Group trigger and `resumereq_i` on the same hart: the hart halts.
- `rst_ni` low mid-handshake: all state is cleared on that edge, with no resume/halt completion.

## Test plan
- NrHarts=4, `hartsel_i`=2, `haltreq_i`=1 at cycle 10 → `debug_req_o`=4'b0100 at 11; `halted_i[2]`=1 at 14 → `debug_req_o`=0 and `allhalted_o`=1 at 15.
- Harts 0,1,3 assigned to group 1 and hart 2 to group 0; `halted_i[0]` rises with no haltreq → `debug_req_o`=4'b1010 next cycle, and hart 2 is untouched.
- `hasel_i`=1, `hamask_i`=4'b1011, harts 0/1/3 halted, `resumereq_i` pulse → `resume_o`=4'b1011 and `allresumeack_o`=0. After `resuming_i` on all three → `allresumeack_o`=1 and `allrunning_o`=1.
- `hartsel_i`=7 (NrHarts=4), `hasel_i`=0 → `allnonexistent_o`=1, all other all* are 0, and `resumereq_i` has no effect.
- After reset, `allhavereset_o`=1; `ackhavereset_i` with hart 1 selected → hart-1 havereset clears. `hart_reset_i[1]` and `ackhavereset_i` in the same cycle → havereset remains 1.
- `haltreq_i` with `resumereq_i` in the same cycle → halt only. `rst_ni` low while `resume_o`=1 → `resume_o`=0 next cycle and `resumeack` is 0.
